// File: rtl/multi_master_arbiter.sv
// ---------------------------------------------------------------------------
// MultiMasterArbiter
//
// Purpose:
//   Shared-bus arbiter for up to 16 masters. It grants the bus to one master
//   at a time, using either round-robin or fixed priority. A granted master
//   keeps the bus until the slave finishes (DONE), splits (SPLIT), retries
//   (RETRY) or the hold timer expires. A locked owner that is still asking
//   for the bus survives DONE and is never timed out. Masters that received
//   SPLIT are parked in SPLIT_MASK until their HSPLIT bit arrives. Every
//   release is followed by at least one IDLE cycle with no grant.
//
// Parameters:
//   NUM_MASTERS  number of bus masters (2..16)
//   MID_W        width of the master index, clog2(NUM_MASTERS)
//   RR_MODE      1 = round-robin, 0 = fixed priority (index 0 highest)
//   TIMEOUT      maximum hold cycles for an unlocked owner, 0 = no timeout
//
// Ports:
//   CLK          clock, all state changes on the rising edge
//   RST          synchronous active-high reset
//   HREQ         per-master bus request
//   HLOCK        per-master locked-transfer request
//   HSPLIT       per-master split release from the slave
//   HRESP        slave response: 00 OKAY, 01 DONE, 10 RETRY, 11 SPLIT
//   HREADY       slave ready, qualifies HRESP
//   HGRANT       one-hot grant, or all zero in IDLE
//   HMAS         index of the current (or most recent) owner
//   MLOCK        current ownership is locked
//   BUSY         high while a master owns the bus
//   SPLIT_MASK   masters currently parked by SPLIT
//   TOUT         one-cycle pulse on a forced timeout release
// ---------------------------------------------------------------------------
module multi_master_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int MID_W       = 2,
  parameter int RR_MODE     = 1,
  parameter int TIMEOUT     = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NUM_MASTERS-1:0] HREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [NUM_MASTERS-1:0] HSPLIT,
  input  logic [1:0]             HRESP,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MID_W-1:0]       HMAS,
  output logic                   MLOCK,
  output logic                   BUSY,
  output logic [NUM_MASTERS-1:0] SPLIT_MASK,
  output logic                   TOUT
);

  // Slave response encodings (OKAY is simply "none of these").
  localparam logic [1:0] RESP_DONE  = 2'b01;
  localparam logic [1:0] RESP_RETRY = 2'b10;
  localparam logic [1:0] RESP_SPLIT = 2'b11;

  // Hold counter saturates at TIMEOUT-1; with no timeout it just sits at 0.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t                 state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [MID_W-1:0]       owner_q;
  logic                   mlock_q;
  logic [NUM_MASTERS-1:0] splitMask_q;
  logic [NUM_MASTERS-1:0] splitMask_d;
  logic                   tout_q;
  logic [MID_W-1:0]       ptr_q;
  logic [CNT_W-1:0]       holdCnt_q;

  logic [NUM_MASTERS-1:0] eligible;
  logic [MID_W-1:0]       winIdx;
  logic                   winFound;
  logic                   respValid;
  logic                   ownerKeeps;
  logic [NUM_MASTERS-1:0] splitSet;

  assign eligible   = HREQ & ~splitMask_q;
  assign respValid  = (state_q == OWN) && HREADY;
  // A locked owner that still wants the bus and still asks for the lock
  // survives a DONE response.
  assign ownerKeeps = mlock_q && HLOCK[owner_q] && HREQ[owner_q];

  // Winner search. In round-robin mode the scan starts at the pointer and
  // wraps; in fixed mode it always starts at index 0. The first hit wins.
  always_comb begin
    int cand;
    cand     = 0;
    winFound = 1'b0;
    winIdx   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand = (RR_MODE != 0) ? ((int'(ptr_q) + i) % NUM_MASTERS) : i;
      if (!winFound && eligible[cand]) begin
        winFound = 1'b1;
        winIdx   = MID_W'(cand);
      end
    end
  end

  // Split mask: HSPLIT releases parked masters, but a SPLIT response for the
  // same master in the same cycle wins, so the set is ORed in after the clear.
  always_comb begin
    splitSet    = (respValid && (HRESP == RESP_SPLIT)) ? grant_q : '0;
    splitMask_d = (splitMask_q & ~HSPLIT) | splitSet;
  end

  // Main arbitration FSM with registered outputs. Every release path clears
  // the grant and lock and goes to IDLE; IDLE only grants on the following
  // edge, which guarantees the mandatory idle gap between owners.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      mlock_q     <= 1'b0;
      splitMask_q <= '0;
      tout_q      <= 1'b0;
      ptr_q       <= '0;
      holdCnt_q   <= '0;
    end else begin
      splitMask_q <= splitMask_d;
      tout_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          holdCnt_q <= '0;
          if (winFound) begin
            state_q   <= OWN;
            grant_q   <= NUM_MASTERS'(1) << winIdx;
            owner_q   <= winIdx;
            mlock_q   <= HLOCK[winIdx];
            ptr_q     <= MID_W'((int'(winIdx) + 1) % NUM_MASTERS);
          end
        end
        OWN: begin
          if (HREADY && (HRESP == RESP_DONE) && ownerKeeps) begin
            holdCnt_q <= '0;
          end else if (HREADY && ((HRESP == RESP_DONE) || (HRESP == RESP_SPLIT) ||
                                  (HRESP == RESP_RETRY))) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            mlock_q   <= 1'b0;
            holdCnt_q <= '0;
          end else if ((TIMEOUT > 0) && !mlock_q && (holdCnt_q == CNT_MAX)) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            holdCnt_q <= '0;
            tout_q    <= 1'b1;
          end else if (holdCnt_q != CNT_MAX) begin
            holdCnt_q <= holdCnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          mlock_q <= 1'b0;
        end
      endcase
    end
  end

  assign HGRANT     = grant_q;
  assign HMAS       = owner_q;
  assign MLOCK      = mlock_q;
  assign BUSY       = (state_q == OWN);
  assign SPLIT_MASK = splitMask_q;
  assign TOUT       = tout_q;

endmodule

// File: tb/tb_multi_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_multi_master_arbiter
//
// Purpose:
//   Directed self-checking bench for MultiMasterArbiter with four masters,
//   round-robin arbitration and a 16-cycle timeout. Inputs change on the
//   falling edge and outputs are sampled on the falling edge, so every
//   stepCycle covers exactly one rising edge of the DUT.
// ---------------------------------------------------------------------------
module tb_multi_master_arbiter;

  localparam logic [1:0] OKAY  = 2'b00;
  localparam logic [1:0] DONE  = 2'b01;
  localparam logic [1:0] RETRY = 2'b10;
  localparam logic [1:0] SPLIT = 2'b11;

  logic       CLK;
  logic       RST;
  logic [3:0] HREQ;
  logic [3:0] HLOCK;
  logic [3:0] HSPLIT;
  logic [1:0] HRESP;
  logic       HREADY;
  logic [3:0] HGRANT;
  logic [1:0] HMAS;
  logic       MLOCK;
  logic       BUSY;
  logic [3:0] SPLIT_MASK;
  logic       TOUT;

  int checkCount;
  int errorCount;

  multi_master_arbiter #(
    .NUM_MASTERS(4),
    .MID_W(2),
    .RR_MODE(1),
    .TIMEOUT(16)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .HREQ(HREQ),
    .HLOCK(HLOCK),
    .HSPLIT(HSPLIT),
    .HRESP(HRESP),
    .HREADY(HREADY),
    .HGRANT(HGRANT),
    .HMAS(HMAS),
    .MLOCK(MLOCK),
    .BUSY(BUSY),
    .SPLIT_MASK(SPLIT_MASK),
    .TOUT(TOUT)
  );

  // Free-running 10 ns clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one set of bus inputs (takes effect at the next rising edge).
  task automatic applyStimulus(input logic [3:0] req, input logic [3:0] lock,
                               input logic [3:0] splitRel, input logic [1:0] resp,
                               input logic ready);
    HREQ   = req;
    HLOCK  = lock;
    HSPLIT = splitRel;
    HRESP  = resp;
    HREADY = ready;
  endtask

  // Advances across one rising edge and lands on the following falling edge.
  task automatic stepCycle();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic doReset();
    RST = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 4'b0000, OKAY, 1'b1);
    repeat (2) stepCycle();
    RST = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " HGRANT"}, 32'(HGRANT), 32'h0);
    checkOutput({tag, " HMAS"}, 32'(HMAS), 32'h0);
    checkOutput({tag, " MLOCK"}, 32'(MLOCK), 32'h0);
    checkOutput({tag, " BUSY"}, 32'(BUSY), 32'h0);
    checkOutput({tag, " SPLIT_MASK"}, 32'(SPLIT_MASK), 32'h0);
    checkOutput({tag, " TOUT"}, 32'(TOUT), 32'h0);
  endtask

  initial begin
    int rrOrder[5];
    int toutSeen;
    int lostGrant;

    checkCount = 0;
    errorCount = 0;
    rrOrder    = '{0, 1, 2, 3, 0};

    // Reset state and single-master grant / release.
    doReset();
    checkAllZero("reset");
    applyStimulus(4'b0001, 4'b0000, 4'b0000, OKAY, 1'b1);
    stepCycle();
    checkOutput("single grant", 32'(HGRANT), 32'h1);
    checkOutput("single HMAS", 32'(HMAS), 32'h0);
    checkOutput("single BUSY", 32'(BUSY), 32'h1);
    applyStimulus(4'b0001, 4'b0000, 4'b0000, DONE, 1'b1);
    stepCycle();
    checkOutput("single release", 32'(HGRANT), 32'h0);
    checkOutput("single release BUSY", 32'(BUSY), 32'h0);

    // Round-robin rotation with DONE on every ownership.
    doReset();
    applyStimulus(4'b1111, 4'b0000, 4'b0000, DONE, 1'b1);
    for (int k = 0; k < 5; k++) begin
      stepCycle();
      checkOutput($sformatf("rr grant %0d", k), 32'(HGRANT), 32'(4'b0001 << rrOrder[k]));
      checkOutput($sformatf("rr HMAS %0d", k), 32'(HMAS), 32'(rrOrder[k]));
      stepCycle();
      checkOutput($sformatf("rr gap %0d", k), 32'(HGRANT), 32'h0);
    end

    // Locked retention of master 1 (pointer is 1 after the rotation).
    applyStimulus(4'b0011, 4'b0010, 4'b0000, OKAY, 1'b1);
    stepCycle();
    checkOutput("lock grant", 32'(HGRANT), 32'h2);
    checkOutput("lock MLOCK", 32'(MLOCK), 32'h1);
    applyStimulus(4'b0011, 4'b0010, 4'b0000, DONE, 1'b1);
    stepCycle();
    checkOutput("lock retained", 32'(HGRANT), 32'h2);
    checkOutput("lock retained MLOCK", 32'(MLOCK), 32'h1);
    applyStimulus(4'b0011, 4'b0000, 4'b0000, DONE, 1'b1);
    stepCycle();
    checkOutput("unlock release", 32'(HGRANT), 32'h0);
    checkOutput("unlock MLOCK", 32'(MLOCK), 32'h0);
    applyStimulus(4'b0011, 4'b0000, 4'b0000, OKAY, 1'b1);
    stepCycle();
    checkOutput("after lock grant", 32'(HGRANT), 32'h1);
    checkOutput("after lock HMAS", 32'(HMAS), 32'h0);

    // SPLIT parking of master 2, including a same-cycle HSPLIT that loses.
    doReset();
    applyStimulus(4'b0100, 4'b0000, 4'b0000, OKAY, 1'b1);
    stepCycle();
    checkOutput("split owner", 32'(HGRANT), 32'h4);
    applyStimulus(4'b0100, 4'b0000, 4'b0100, SPLIT, 1'b1);
    stepCycle();
    checkOutput("split release", 32'(HGRANT), 32'h0);
    checkOutput("split mask set", 32'(SPLIT_MASK), 32'h4);
    applyStimulus(4'b0100, 4'b0000, 4'b0000, OKAY, 1'b1);
    repeat (2) stepCycle();
    checkOutput("split parked", 32'(HGRANT), 32'h0);
    checkOutput("split parked BUSY", 32'(BUSY), 32'h0);
    checkOutput("split mask held", 32'(SPLIT_MASK), 32'h4);
    applyStimulus(4'b0100, 4'b0000, 4'b0100, OKAY, 1'b1);
    stepCycle();
    checkOutput("split mask cleared", 32'(SPLIT_MASK), 32'h0);
    applyStimulus(4'b0100, 4'b0000, 4'b0000, OKAY, 1'b1);
    stepCycle();
    checkOutput("split regrant", 32'(HGRANT), 32'h4);

    // Timeout of an unlocked owner with the slave stalled.
    doReset();
    applyStimulus(4'b0001, 4'b0000, 4'b0000, OKAY, 1'b0);
    stepCycle();
    checkOutput("tout grant", 32'(HGRANT), 32'h1);
    toutSeen = 0;
    for (int c = 0; c < 15; c++) begin
      stepCycle();
      if (TOUT) toutSeen++;
    end
    checkOutput("tout still owned", 32'(HGRANT), 32'h1);
    checkOutput("tout early pulses", 32'(toutSeen), 32'h0);
    stepCycle();
    checkOutput("tout pulse", 32'(TOUT), 32'h1);
    checkOutput("tout release", 32'(HGRANT), 32'h0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, OKAY, 1'b0);
    stepCycle();
    checkOutput("tout one cycle", 32'(TOUT), 32'h0);

    // A locked owner is never timed out.
    applyStimulus(4'b0001, 4'b0001, 4'b0000, OKAY, 1'b0);
    stepCycle();
    checkOutput("locked owner grant", 32'(HGRANT), 32'h1);
    toutSeen  = 0;
    lostGrant = 0;
    for (int c = 0; c < 40; c++) begin
      stepCycle();
      if (TOUT) toutSeen++;
      if (HGRANT != 4'b0001) lostGrant++;
    end
    checkOutput("locked no tout", 32'(toutSeen), 32'h0);
    checkOutput("locked no release", 32'(lostGrant), 32'h0);

    // Reset while master 3 owns a locked transfer; reset beats SPLIT.
    doReset();
    applyStimulus(4'b1000, 4'b1000, 4'b0000, OKAY, 1'b1);
    stepCycle();
    checkOutput("m3 grant", 32'(HGRANT), 32'h8);
    checkOutput("m3 MLOCK", 32'(MLOCK), 32'h1);
    RST = 1'b1;
    applyStimulus(4'b1111, 4'b1000, 4'b0000, SPLIT, 1'b1);
    stepCycle();
    checkAllZero("mid reset");
    RST = 1'b0;
    applyStimulus(4'b1111, 4'b0001, 4'b0000, OKAY, 1'b1);
    stepCycle();
    checkOutput("post reset grant", 32'(HGRANT), 32'h1);
    checkOutput("post reset MLOCK", 32'(MLOCK), 32'h1);

    // RETRY drops the lock and releases.
    applyStimulus(4'b1111, 4'b0001, 4'b0000, RETRY, 1'b1);
    stepCycle();
    checkOutput("retry release", 32'(HGRANT), 32'h0);
    checkOutput("retry MLOCK", 32'(MLOCK), 32'h0);
    applyStimulus(4'b1111, 4'b0000, 4'b0000, OKAY, 1'b1);
    stepCycle();
    checkOutput("retry next grant", 32'(HGRANT), 32'h2);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/multi_master_arbiter.md
MULTI_MASTER_ARBITER -- requirements
Module: multi_master_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_MASTERS, default 4, number of bus masters (2..16).
REQ-002 The block SHALL have parameter MID_W, default 2, width of master index, equal to clog2(NUM_MASTERS).
REQ-003 The block SHALL have parameter RR_MODE, default 1, arbitration mode: 1 = round-robin, 0 = fixed priority with index 0 highest.
REQ-004 The block SHALL have parameter TIMEOUT, default 16, maximum cycles an unlocked owner holds the bus before forced release; 0 disables the timeout.
REQ-005 The block SHALL have port CLK, input, 1 bit, the single clock; all state updates on rising edge.
REQ-006 The block SHALL have port RST, input, 1 bit, reset; synchronous and active-high.
REQ-007 The block SHALL have port HREQ, input, NUM_MASTERS bits, bus request, one bit per master.
REQ-008 The block SHALL have port HLOCK, input, NUM_MASTERS bits, locked-transfer request, one bit per master.
REQ-009 The block SHALL have port HSPLIT, input, NUM_MASTERS bits, slave split-release, one bit per master.
REQ-010 The block SHALL have port HRESP, input, 2 bits, slave response: 00 OKAY, 01 DONE, 10 RETRY, 11 SPLIT.
REQ-011 The block SHALL have port HREADY, input, 1 bit, slave ready; HRESP is valid only when HREADY=1.
REQ-012 The block SHALL have port HGRANT, output, NUM_MASTERS bits, one-hot grant, or all-zero.
REQ-013 The block SHALL have port HMAS, output, MID_W bits, index of current owner.
REQ-014 The block SHALL have port MLOCK, output, 1 bit, current ownership is locked.
REQ-015 The block SHALL have port BUSY, output, 1 bit, high while in state OWN.
REQ-016 The block SHALL have port SPLIT_MASK, output, NUM_MASTERS bits, masters currently parked by SPLIT.
REQ-017 The block SHALL have port TOUT, output, 1 bit, one-cycle pulse on forced timeout release.

Function
REQ-018 The block SHALL implement two states: IDLE (no grant) and OWN (exactly one HGRANT bit high).
REQ-019 In IDLE, the eligible set SHALL be HREQ & ~SPLIT_MASK; if it is non-empty, the block SHALL register the winner in HGRANT/HMAS, set MLOCK=HLOCK[winner], load hold counter=0 and enter OWN at the same edge, giving 1-cycle request-to-grant latency.
REQ-020 In IDLE with an empty eligible set, the block SHALL stay in IDLE with HGRANT=0 and hold HMAS at its last value.
REQ-021 With RR_MODE=0, the winner SHALL be the lowest eligible index.
REQ-022 With RR_MODE=1, the search SHALL start at pointer PTR, wrapping from NUM_MASTERS-1 to 0; on each grant PTR SHALL become (winner+1) mod NUM_MASTERS.
REQ-023 In OWN, HREQ/HLOCK changes of the owner SHALL NOT alter the grant; release occurs only per REQ-024 to REQ-027.
REQ-024 On HREADY=1 & HRESP=DONE: if MLOCK=1, HLOCK[owner]=1 and HREQ[owner]=1, the block SHALL stay in OWN with the same owner and reset the hold counter; otherwise it SHALL clear HGRANT and MLOCK and go to IDLE.
REQ-025 On HREADY=1 & HRESP=SPLIT, the block SHALL set SPLIT_MASK[owner], clear HGRANT and MLOCK, and go to IDLE, irrespective of lock.
REQ-026 On HREADY=1 & HRESP=RETRY, the block SHALL clear HGRANT and MLOCK and go to IDLE; the lock is dropped and PTR is unchanged.
REQ-027 Timeout: when TIMEOUT>0, MLOCK=0, and the hold counter reaches TIMEOUT-1 in OWN without a release, the block SHALL release to IDLE and pulse TOUT for 1 cycle; when MLOCK=1 the counter SHALL saturate with no release.
REQ-028 The hold counter SHALL increment each OWN cycle, saturate at TIMEOUT-1, and be zero in IDLE.
REQ-029 Each set HSPLIT[i] bit SHALL clear SPLIT_MASK[i] at the next edge; a same-cycle SPLIT set for the same master SHALL take priority over the clear.
REQ-030 After any release there SHALL be at least one IDLE cycle with HGRANT=0 before the next grant.
REQ-031 HRESP=OKAY, or any HRESP with HREADY=0, SHALL cause no state change except the counter update.

Reset
REQ-032 When RST=1 at a clock edge, the block SHALL return to IDLE with HGRANT=0, HMAS=0, MLOCK=0, BUSY=0, SPLIT_MASK=0, TOUT=0, PTR=0 and hold counter=0, including when reset is asserted mid-ownership.
REQ-033 Reset SHALL take priority over every other event in the same cycle.

Verification (NUM_MASTERS=4, RR_MODE=1, TIMEOUT=16)
REQ-034 The bench SHALL check: after reset, HREQ=0001 -> HGRANT=0001 and HMAS=0 one cycle later; DONE -> HGRANT=0000 next cycle.
REQ-035 The bench SHALL check: HREQ=1111 held with DONE on every ownership -> grant order 0,1,2,3,0 with one IDLE gap between each.
REQ-036 The bench SHALL check: master 1 owns with HLOCK=0010 and HREQ=0011, then DONE -> master 1 retained and MLOCK=1; HLOCK then dropped, DONE -> release and master 0 granted after the IDLE gap.
REQ-037 The bench SHALL check: master 2 receives SPLIT -> SPLIT_MASK=0100 and master 2 not granted despite HREQ[2]=1; HSPLIT=0100 -> mask cleared and master 2 eligible.
REQ-038 The bench SHALL check: unlocked owner with no response for 16 cycles -> TOUT pulses once and HGRANT=0000; a locked owner in the same situation is never released.
REQ-039 The bench SHALL check: RST asserted while master 3 is locked-owning -> all outputs zero at the next edge and PTR=0, so HREQ=1111 grants master 0 first.
